// File: rtl/uart_rx_oversample.sv
// UART receiver driven by an 8x oversampling tick; mid-bit sampling, framing/overrun checks.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversample #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst_n,
  input  logic                 i_bclkx8,
  input  logic                 i_rxd,
  input  logic                 i_rd_ack,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rdrf,
  output logic                 o_fe,
  output logic                 o_oe,
  output logic                 o_pe,
  output logic                 o_rx_busy
);

  localparam logic [3:0] LastIdx = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e               r_state;
  logic                 r_rxd_meta;
  logic                 r_rxd_s;
  logic                 r_bx8_q;
  logic                 r_armed;
  logic                 r_busy;
  logic [2:0]           r_cnt;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rdrf;
  logic                 r_fe;
  logic                 r_oe;

  logic w_tick;
  logic w_sample;
  logic w_stop_tick;
  logic w_par_bad;
  logic w_good;

  // Synchronizer and tick edge register reset high so idle/high inputs cause no events.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_rxd_meta <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_bx8_q    <= 1'b1;
    end else begin
      r_rxd_meta <= i_rxd;
      r_rxd_s    <= r_rxd_meta;
      r_bx8_q    <= i_bclkx8;
    end
  end

  assign w_tick      = i_bclkx8 & ~r_bx8_q;
  assign w_sample    = w_tick & (r_cnt == 3'd7);
  assign w_stop_tick = w_sample & (r_state == StStop);

`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic r_pe;
  assign w_par_bad = (^r_shreg) ^ r_par;
  assign o_pe      = r_pe;
`else
  assign w_par_bad = 1'b0;
  assign o_pe      = 1'b0;
`endif

  assign w_good = w_stop_tick & r_rxd_s & ~w_par_bad;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 3'd0;
      r_idx   <= 4'd0;
      r_shreg <= '0;
      r_armed <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_tick) begin
      if (r_rxd_s) r_armed <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (r_armed && !r_rxd_s) begin
            r_state <= StStart;
            r_cnt   <= 3'd1;
            r_armed <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        StStart: begin
          if (r_rxd_s) begin
            r_state <= StIdle;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b0;
          end else if (r_cnt == 3'd3) begin
            r_state <= StData;
            r_cnt   <= 3'd0;
            r_idx   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        StData: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_shreg <= {r_rxd_s, r_shreg[DATA_BITS-1:1]};
            r_idx   <= r_idx + 4'd1;
            if (r_idx == LastIdx) begin
`ifdef UART_RX_PARITY_EN
              r_state <= StParity;
`else
              r_state <= StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_par   <= r_rxd_s;
            r_state <= StStop;
          end
        end
`endif
        StStop: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            // A low stop bit means the line may be in break; wait for it to go high again.
            if (!r_rxd_s) r_armed <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // rd_ack clears first; completion on the same edge overrides the flags it sets.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_rx_data <= '0;
      r_rdrf    <= 1'b0;
      r_fe      <= 1'b0;
      r_oe      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pe      <= 1'b0;
`endif
    end else begin
      if (i_rd_ack) begin
        r_rdrf <= 1'b0;
        r_fe   <= 1'b0;
        r_oe   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_pe   <= 1'b0;
`endif
      end
      if (w_stop_tick) begin
        if (!r_rxd_s) r_fe <= 1'b1;
`ifdef UART_RX_PARITY_EN
        if (w_par_bad) r_pe <= 1'b1;
`endif
        if (w_good) begin
          if (!r_rdrf || i_rd_ack) begin
            r_rx_data <= r_shreg;
            r_rdrf    <= 1'b1;
          end else begin
            r_oe <= 1'b1;
          end
        end
      end
    end
  end

  assign o_rx_data = r_rx_data;
  assign o_rdrf    = r_rdrf;
  assign o_fe      = r_fe;
  assign o_oe      = r_oe;
  assign o_rx_busy = r_busy;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: directed and random frames against a frame-level model.
// Honours UART_RX_PARITY_EN to send a parity bit when the DUT is built with parity.
module tb_uart_rx_oversample;

  localparam int unsigned DATA_BITS = 8;
  localparam int BitIt = 32;  // sys_clk cycles per bit: 8 ticks, one tick every 4 cycles
`ifdef UART_RX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       bclkx8;
  logic       rxd;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rdrf, fe, oe, pe, rx_busy;

  int it;
  int ack_at;
  int tests;
  int fails;
  bit busy_seen;

  logic [7:0] m_data;
  bit         m_rdrf, m_fe, m_oe, m_pe;

  uart_rx_oversample #(.DATA_BITS(DATA_BITS)) dut (
    .i_sys_clk  (sys_clk),
    .i_sys_rst_n(sys_rst_n),
    .i_bclkx8   (bclkx8),
    .i_rxd      (rxd),
    .i_rd_ack   (rd_ack),
    .o_rx_data  (rx_data),
    .o_rdrf     (rdrf),
    .o_fe       (fe),
    .o_oe       (oe),
    .o_pe       (pe),
    .o_rx_busy  (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_data"}, 32'(rx_data), 32'(m_data));
    chk({tag, "_rdrf"}, 32'(rdrf), 32'(m_rdrf));
    chk({tag, "_fe"}, 32'(fe), 32'(m_fe));
    chk({tag, "_oe"}, 32'(oe), 32'(m_oe));
    chk({tag, "_pe"}, 32'(pe), 32'(m_pe));
    chk({tag, "_busy"}, 32'(rx_busy), 32'd0);
  endtask

  // One sys_clk cycle; inputs change on the falling edge, outputs sampled there too.
  task automatic step(input bit b);
    @(negedge sys_clk);
    it++;
    rxd    = b;
    bclkx8 = (it % 4 == 0);
    rd_ack = (it == ack_at);
    if (rx_busy) busy_seen = 1'b1;
  endtask

  task automatic drive_bit(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  task automatic do_ack();
    ack_at = it + 1;
    step(1'b1);
    ack_at = -1;
    step(1'b1);
    m_rdrf = 0; m_fe = 0; m_oe = 0; m_pe = 0;
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_rdrf = 0; m_fe = 0; m_oe = 0; m_pe = 0;
  endtask

  // Sends a whole frame; ack_co places rd_ack on the exact cycle of the stop-bit sample.
  task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit par_b,
                            input bit ack_co);
    int i0;
    int s;
    int nt;
    bit par_ok;
    bit was_full;
    i0 = it + 1;
    s  = i0 + 2;
    while (s % 4 != 0) s++;
    nt = 3 + 8 * (DATA_BITS + 1) + (ParEn ? 8 : 0);
    ack_at = ack_co ? s + 4 * nt : -1;
    drive_bit(1'b0, BitIt);
    for (int k = 0; k < 8; k++) drive_bit(d[k], BitIt);
    if (ParEn) drive_bit(par_b, BitIt);
    drive_bit(stop_b, BitIt);
    ack_at = -1;
    par_ok   = !ParEn || (((^d) ^ par_b) == 1'b0);
    was_full = m_rdrf;
    if (ack_co) begin
      m_rdrf = 0; m_fe = 0; m_oe = 0; m_pe = 0;
    end
    if (!stop_b) m_fe = 1;
    if (!par_ok) m_pe = 1;
    if (stop_b && par_ok) begin
      if (!was_full || ack_co) begin
        m_data = d;
        m_rdrf = 1;
      end else begin
        m_oe = 1;
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    bit         sb;
    bit         pb;
    it = 0; ack_at = -1; tests = 0; fails = 0; busy_seen = 0;
    rxd = 1'b1; bclkx8 = 1'b0; rd_ack = 1'b0; sys_rst_n = 1'b0;
    model_reset();

    drive_bit(1'b1, 3);
    check_all("reset");
    sys_rst_n = 1'b1;
    drive_bit(1'b1, 40);

    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
    check_all("good_a5");
    do_ack();
    chk("ack_rdrf", 32'(rdrf), 32'd0);

    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
    check_all("frame_err");
    busy_seen = 0;
    drive_bit(1'b0, 80);
    chk("break_no_start", 32'(busy_seen), 32'd0);
    drive_bit(1'b1, 40);
    do_ack();
    check_all("fe_cleared");

    busy_seen = 0;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 64);
    chk("glitch_started", 32'(busy_seen), 32'd1);
    check_all("glitch");
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
    check_all("after_glitch");
    do_ack();
    drive_bit(1'b1, 16);

    send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
    drive_bit(1'b1, 16);
    send_frame(8'h22, 1'b1, ^8'h22, 1'b0);
    check_all("overrun");
    do_ack();
    drive_bit(1'b1, 16);
    send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
    drive_bit(1'b1, 16);
    send_frame(8'h22, 1'b1, ^8'h22, 1'b1);
    check_all("ack_at_stop");
    do_ack();
    drive_bit(1'b1, 16);

    if (ParEn) begin
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      check_all("par_good");
      drive_bit(1'b1, 16);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      check_all("par_bad");
      do_ack();
      drive_bit(1'b1, 16);
    end

    for (int n = 0; n < 10; n++) begin
      d  = 8'($urandom);
      sb = ($urandom % 4) != 0;
      pb = (^d) ^ (($urandom % 4) == 0);
      if ($urandom % 2 == 1) do_ack();
      send_frame(d, sb, pb, 1'($urandom % 2));
      check_all("rand");
      drive_bit(1'b1, 16 + int'($urandom % 8));
    end

    send_frame(8'h96, 1'b1, ^8'h96, 1'b0);
    drive_bit(1'b1, 16);
    d = 8'hC3;
    drive_bit(1'b0, BitIt);
    for (int k = 0; k < 4; k++) drive_bit(d[k], BitIt);
    drive_bit(d[4], 16);
    chk("midframe_busy", 32'(rx_busy), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    drive_bit(1'b0, 2);
    sys_rst_n = 1'b1;
    busy_seen = 0;
    drive_bit(1'b0, 40);
    chk("no_start_until_high", 32'(busy_seen), 32'd0);
    drive_bit(1'b1, 40);
    send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0);
    check_all("after_reset_c3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
# uart_rx_oversample

UART receiver that consumes the 8x-oversampling baud clock from the baud-rate generator and turns the serial `rxd` line into parallel bytes. It sits directly downstream of the generator's `bclkx8` output, in the `sys_clk` domain. It detects start bits, samples each bit at mid-bit, checks the stop bit and presents each received word behind a full/acknowledge flag.

## Interface
- `DATA_BITS`, 8: data bits per frame, sent LSB first; legal range 5–8.
- `sys_clk` input 1: system clock; all state changes on its rising edge.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `bclkx8` input 1: 8x baud clock from the baud-rate generator; treated as data, never used as a clock.
- `rxd` input 1: asynchronous serial line; idles high.
- `rd_ack` input 1: one-cycle pulse; consumer has read `rx_data`.
- `rx_data` output DATA_BITS: last accepted word.
- `rdrf` output 1: receive data register full.
- `fe` output 1: framing error, sticky.
- `oe` output 1: overrun error, sticky.
- `pe` output 1: parity error, sticky; see Configuration.
- `rx_busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- `rxd` passes through a 2-FF synchronizer to give `rxd_s`.
- `bclkx8` is registered into `bx8_q`. A tick is `bclkx8 & ~bx8_q`, one `sys_clk` wide. All FSM activity advances only on ticks.
- A 3-bit counter `cnt` runs inside each state. A bit index `idx` counts data bits.
- `armed` is set on any tick with `rxd_s=1` and cleared on start detection. This blocks re-triggering on a line held low (break condition).
- FSM states:
  - IDLE: on a tick with `armed=1` and `rxd_s=0`, go to START with `cnt<=1`.
  - START: on any tick with `rxd_s=1`, return to IDLE (glitch reject). Otherwise increment `cnt`. On the tick where `cnt==3` (4th low tick, mid start bit), go to DATA with `cnt<=0`, `idx<=0`.
  - DATA: increment `cnt` each tick. On the tick with `cnt==7`, shift `rxd_s` into the MSB of `shreg` (right shift) and increment `idx`. After sample number DATA_BITS, go to PARITY if enabled, else STOP.
  - PARITY: on the tick with `cnt==7`, capture the parity bit, then go to STOP.
  - STOP: on the tick with `cnt==7`, sample the stop bit, run frame completion, go to IDLE.
- Frame completion, evaluated on the stop-sample tick:
  - Stop bit is 0: `fe<=1`. `rx_data` and `rdrf` are unchanged.
  - Parity is wrong (when enabled): `pe<=1`. `rx_data` and `rdrf` are unchanged.
  - Frame is good, and either `rdrf=0` or `rd_ack` is high in the same cycle: `rx_data<=shreg`, `rdrf<=1`.
  - Frame is good, `rdrf=1` and no `rd_ack`: `oe<=1`. The new word is discarded and the old `rx_data` is kept.
- `rd_ack` clears `rdrf`, `fe`, `oe` and `pe`.
  - If `rd_ack` coincides with frame completion, completion wins for the flags it sets.
  - In that same case, `rdrf` stays 1 with the new data.
- A change of `sel_baud` in mid-frame only changes the tick rate. The frame in progress may be corrupted; the FSM still returns to IDLE.

## Timing
- Reset values:
  - Outputs: `rx_data=0`, `rdrf=0`, `fe=0`, `oe=0`, `pe=0`, `rx_busy=0`.
  - State IDLE, `cnt=0`, `idx=0`, `shreg=0`.
  - Synchronizer FFs = 1, `bx8_q=1` (so a high `bclkx8` at reset release does not produce a spurious tick), `armed=0`.
- Input latency: 2 `sys_clk` from `rxd` to `rxd_s`, plus 1 `sys_clk` of edge detection on `bclkx8`.
- Flag latency: `rdrf`, `fe`, `oe` and `pe` change on the `sys_clk` edge immediately following the stop-sample tick.
- Sample points, measured from start detection (tick 0):
  - Start check: tick 3.
  - Data bit k: tick 3 + 8(k+1).
  - Stop bit: tick 3 + 8(DATA_BITS+1), or tick 3 + 8(DATA_BITS+2) with parity.
- `rx_busy` rises the cycle after start detection and falls the cycle after the stop-sample tick.
- Reset asserted mid-frame: all registers return to reset values immediately. Reception restarts only after `rxd_s` is seen high on a tick.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
  - Defined: one even-parity bit is received between the data bits and the stop bit. `pe` is set when the XOR of the data bits and the parity bit is 1.
  - Undefined: the PARITY state and parity logic are absent, and `pe` is tied to 0.

## Test plan
- Good frame: frame 0xA5 with stop=1, 8N1, driven from the baud generator at `sel_baud=2'b11` → `rx_data=0xA5`, `rdrf=1`, `fe=oe=pe=0`; `rd_ack` pulse → `rdrf=0`.
- Framing error: 0x3C sent with stop bit 0 → `fe=1`, `rdrf=0`, `rx_data` unchanged. The line is then held low for 20 ticks → no new start detected until `rxd` returns high.
- Glitch reject: `rxd` low for 2 ticks, then high → `rx_busy` returns to 0 with no flags set. A following 0x5A frame is received correctly.
- Overrun: 0x11 then 0x22 with no `rd_ack` → `rx_data=0x11`, `oe=1`. Repeat with `rd_ack` in the same cycle as 0x22's stop sample → `rx_data=0x22`, `rdrf=1`, `oe=0`.
- Parity, with `UART_RX_PARITY_EN` defined: 0x07 with parity bit 1 → `rdrf=1`, `pe=0`. 0x07 with parity bit 0 → `pe=1`, `rdrf` unchanged.
- Reset mid-frame: `sys_rst_n` pulsed low during data bit 4 → all outputs 0 at once. The next 0xC3 frame is received correctly.
